// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- request/response sequencer in front of a fixed-latency ALU.
//
// A request (op code, two operand bytes, carry-in) is accepted on a
// valid/ready handshake. The operands and a one-hot op are then presented to
// an external ALU and held steady for ALU_LAT clock edges. After that the
// ALU's result and flags are captured and offered on the response port until
// the consumer takes them. A new request may be accepted in the same cycle a
// response is consumed, so back-to-back operations leave no idle cycle.
//
// Parameters
//   ALU_LAT   clock edges from operand drive to valid alu_d/alu_fo (1..15)
//
// Optional feature (compile-time macro)
//   ALU_SEQ_CHAIN_EN  when defined, the carry-out (alu_fo[0]) of each captured
//                     result is stored; a request with req_chain=1 then uses it
//                     as carry-in instead of req_carry. When undefined,
//                     req_chain is ignored and no carry state exists.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid and req_ready are both high
//   req_code   in   op: 1 add, 2 sub, 3 and, 4 or, 5 not, 6 shl, 7 shr, 0 null
//   req_a      in   operand A
//   req_b      in   operand B
//   req_carry  in   carry-in
//   req_chain  in   use stored carry as carry-in (chain build only)
//   rsp_valid  out  result held
//   rsp_ready  in   consumer accepts result
//   rsp_d      out  result byte
//   rsp_flags  out  ALU flags (bit0 carry, bit1 zero, bit2 signed-positive)
//   alu_op     out  one-hot op to ALU (bit code-1; all zero for null)
//   alu_a      out  operand A to ALU
//   alu_b      out  operand B to ALU
//   alu_fi     out  flags-in to ALU ({7'b0, carry-in})
//   alu_d      in   ALU result
//   alu_fo     in   ALU flags-out
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int ALU_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_code,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic       req_carry,
   input  logic       req_chain,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_d,
   output logic [7:0] rsp_flags,
   output logic [6:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [7:0] alu_fi,
   input  logic [7:0] alu_d,
   input  logic [7:0] alu_fo
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // The counter starts at ALU_LAT-1 on the accepting edge and the result is
   // captured on the edge where it is already zero, which makes the capture
   // edge exactly ALU_LAT edges after acceptance.
   localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] alu_op_q, alu_op_d;
   logic [7:0] alu_a_q, alu_a_d;
   logic [7:0] alu_b_q, alu_b_d;
   logic [7:0] alu_fi_q, alu_fi_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_d_q, rsp_d_d;
   logic [7:0] rsp_flags_q, rsp_flags_d;

   logic       accept;
   logic       carry_in;

`ifdef ALU_SEQ_CHAIN_EN
   logic       carry_q, carry_d;
`else
   // Chaining is compiled out; the input exists only to keep the port list
   // identical between builds.
   logic       unused_chain;
   assign unused_chain = req_chain;
`endif

   // One-hot op select: code n drives bit n-1, the null code drives nothing.
   function automatic logic [6:0] op_onehot(input logic [2:0] code);
      logic [6:0] op;
      op = 7'd0;
      if (code != 3'd0) begin
         op[code - 3'd1] = 1'b1;
      end
      return op;
   endfunction

   // Ready while idle, or while a held response is being consumed this cycle
   // (this is what allows the zero-bubble back-to-back case). Gated by rst so
   // nothing is advertised while reset is asserted.
   assign req_ready = rst & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
   assign accept    = req_valid & req_ready;

`ifdef ALU_SEQ_CHAIN_EN
   assign carry_in = req_chain ? carry_q : req_carry;
`else
   assign carry_in = req_carry;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_fi_d    = alu_fi_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d_d     = rsp_d_q;
      rsp_flags_d = rsp_flags_q;
`ifdef ALU_SEQ_CHAIN_EN
      carry_d     = carry_q;
`endif

      case (state_q)
         IDLE: begin
            // Waiting for a request; acceptance is handled below.
         end

         ISSUE: begin
            if (cnt_q == 4'd0) begin
               rsp_d_d     = alu_d;
               rsp_flags_d = alu_fo;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
`ifdef ALU_SEQ_CHAIN_EN
               carry_d     = alu_fo[0];
`endif
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
               alu_op_d    = 7'd0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Acceptance overrides the idle fall-through above so a response
      // handshake and a new request on the same edge go straight to ISSUE.
      if (accept) begin
         state_d  = ISSUE;
         cnt_d    = CNT_LOAD;
         alu_op_d = op_onehot(req_code);
         alu_a_d  = req_a;
         alu_b_d  = req_b;
         alu_fi_d = {7'd0, carry_in};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         alu_op_q    <= 7'd0;
         alu_a_q     <= 8'd0;
         alu_b_q     <= 8'd0;
         alu_fi_q    <= 8'd0;
         rsp_valid_q <= 1'b0;
         rsp_d_q     <= 8'd0;
         rsp_flags_q <= 8'd0;
`ifdef ALU_SEQ_CHAIN_EN
         carry_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_fi_q    <= alu_fi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_d_q     <= rsp_d_d;
         rsp_flags_q <= rsp_flags_d;
`ifdef ALU_SEQ_CHAIN_EN
         carry_q     <= carry_d;
`endif
      end
   end

   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_fi    = alu_fi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_d     = rsp_d_q;
   assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
// The external ALU is a behavioural stub that decodes the one-hot op; expected
// responses come from a reference of the op rules applied to the request
// fields, with the chained carry tracked across completed operations.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int LAT = 4;
`ifdef ALU_SEQ_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_code;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       req_carry;
   logic       req_chain;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_d;
   logic [7:0] rsp_flags;
   logic [6:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_fi;
   logic [7:0] alu_d;
   logic [7:0] alu_fo;

   int checks = 0;
   int errors = 0;

   logic        ref_carry;
   logic [2:0]  exp_code;
   logic [7:0]  exp_a;
   logic [7:0]  exp_b;
   logic [7:0]  exp_fi;
   logic [15:0] exp_rsp;
   bit          pending;

   always #5 clk = ~clk;

   alu_seq #(.ALU_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_code  (req_code),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_carry (req_carry),
      .req_chain (req_chain),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_d     (rsp_d),
      .rsp_flags (rsp_flags),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_fi    (alu_fi),
      .alu_d     (alu_d),
      .alu_fo    (alu_fo)
   );

   // Op rules: returns {flags, result}; flags = {5'b0, signed-positive, zero, carry}.
   function automatic logic [15:0] ref_alu(input logic [2:0] code, input logic [7:0] a,
                                           input logic [7:0] b, input logic ci);
      logic [8:0] s;
      case (code)
         3'd1:    s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
         3'd2:    s = {1'b0, a} - {1'b0, b} - {8'd0, ci};
         3'd3:    s = {1'b0, a & b};
         3'd4:    s = {1'b0, a | b};
         3'd5:    s = {1'b0, ~a};
         3'd6:    s = {a, 1'b0};
         3'd7:    s = {a[0], 1'b0, a[7:1]};
         default: s = 9'd0;
      endcase
      return {5'd0, ~s[7], (s[7:0] == 8'd0), s[8], s[7:0]};
   endfunction

   // ALU stub: anything other than zero or one-hot op yields a marker value.
   function automatic logic [15:0] alu_stub(input logic [6:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] fi);
      logic [2:0] code;
      code = 3'd0;
      if (op != 7'd0 && $countones(op) != 1) return 16'hFFEE;
      for (int i = 0; i < 7; i++) begin
         if (op[i]) code = 3'(i + 1);
      end
      return ref_alu(code, a, b, fi[0]);
   endfunction

   function automatic logic [6:0] exp_op(input logic [2:0] code);
      case (code)
         3'd1:    return 7'b0000001;
         3'd2:    return 7'b0000010;
         3'd3:    return 7'b0000100;
         3'd4:    return 7'b0001000;
         3'd5:    return 7'b0010000;
         3'd6:    return 7'b0100000;
         3'd7:    return 7'b1000000;
         default: return 7'b0000000;
      endcase
   endfunction

   assign {alu_fo, alu_d} = alu_stub(alu_op, alu_a, alu_b, alu_fi);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_d",     32'(rsp_d),     32'h0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
      check("rst_alu_op",    32'(alu_op),    32'h0);
      check("rst_alu_a",     32'(alu_a),     32'h0);
      check("rst_alu_b",     32'(alu_b),     32'h0);
      check("rst_alu_fi",    32'(alu_fi),    32'h0);
   endtask

   // Present a request and let it be accepted on the next edge (from IDLE, or
   // from RESP where the same edge also consumes the held response).
   task automatic accept(input logic [2:0] code, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic ch);
      logic cin;
      req_valid = 1'b1;
      req_code  = code;
      req_a     = a;
      req_b     = b;
      req_carry = c;
      req_chain = ch;
      rsp_ready = 1'b1;
      cin       = (CHAIN && ch) ? ref_carry : c;
      exp_code  = code;
      exp_a     = a;
      exp_b     = b;
      exp_fi    = {7'd0, cin};
      exp_rsp   = ref_alu(code, a, b, cin);
      #1;
      check("req_ready_accept", 32'(req_ready), 32'h1);
      tick();
      req_valid = 1'b0;
   endtask

   // Called just after the accepting edge; walks the ISSUE window and checks
   // the response appears exactly LAT edges after acceptance.
   task automatic run_issue();
      for (int k = 0; k < LAT; k++) begin
         check("rsp_valid_issue", 32'(rsp_valid), 32'h0);
         check("req_ready_issue", 32'(req_ready), 32'h0);
         check("alu_op",          32'(alu_op),    32'(exp_op(exp_code)));
         check("alu_a",           32'(alu_a),     32'(exp_a));
         check("alu_b",           32'(alu_b),     32'(exp_b));
         check("alu_fi",          32'(alu_fi),    32'(exp_fi));
         req_valid = 1'($urandom);
         req_code  = 3'($urandom);
         req_a     = 8'($urandom);
         req_b     = 8'($urandom);
         req_carry = 1'($urandom);
         req_chain = 1'($urandom);
         rsp_ready = 1'($urandom);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      #1;
      check("rsp_valid_at_lat", 32'(rsp_valid), 32'h1);
      check("rsp_d",            32'(rsp_d),     32'(exp_rsp[7:0]));
      check("rsp_flags",        32'(rsp_flags), 32'(exp_rsp[15:8]));
      ref_carry = exp_rsp[8];
   endtask

   task automatic backpressure(input int n);
      rsp_ready = 1'b0;
      for (int k = 0; k < n; k++) begin
         req_valid = 1'b1;
         req_code  = 3'($urandom);
         req_a     = 8'($urandom);
         req_b     = 8'($urandom);
         tick();
         check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
         check("bp_rsp_d",     32'(rsp_d),     32'(exp_rsp[7:0]));
         check("bp_rsp_flags", 32'(rsp_flags), 32'(exp_rsp[15:8]));
         check("bp_req_ready", 32'(req_ready), 32'h0);
         check("bp_alu_a",     32'(alu_a),     32'(exp_a));
      end
      req_valid = 1'b0;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      #1;
      check("req_ready_resp", 32'(req_ready), 32'h1);
      tick();
      check("rsp_valid_drop", 32'(rsp_valid), 32'h0);
      check("alu_op_idle",    32'(alu_op),    32'h0);
      check("req_ready_idle", 32'(req_ready), 32'h1);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_code  = 3'd0;
      req_a     = 8'd0;
      req_b     = 8'd0;
      req_carry = 1'b0;
      req_chain = 1'b0;
      rsp_ready = 1'b0;
      ref_carry = 1'b0;
      pending   = 1'b0;

      // Reset state
      tick();
      tick();
      check_reset();
      rst = 1'b1;
      tick();
      check("req_ready_after_rst", 32'(req_ready), 32'h1);
      check("rsp_valid_after_rst", 32'(rsp_valid), 32'h0);

      // Add with latency, then backpressure for six cycles
      accept(3'd1, 8'h3C, 8'h05, 1'b0, 1'b0);
      run_issue();
      check("add_d",    32'(rsp_d),        32'h41);
      check("add_zero", 32'(rsp_flags[1]), 32'h0);
      backpressure(6);
      release_rsp();

      // Back-to-back: AND then OR with the handshake and accept on one edge
      accept(3'd3, 8'hF0, 8'h3C, 1'b0, 1'b0);
      run_issue();
      check("and_d", 32'(rsp_d), 32'h30);
      accept(3'd4, 8'h0F, 8'h30, 1'b0, 1'b0);
      run_issue();
      check("or_d", 32'(rsp_d), 32'h3F);
      release_rsp();

      // Null op
      accept(3'd0, 8'h55, 8'hAA, 1'b0, 1'b0);
      run_issue();
      check("null_d", 32'(rsp_d), 32'h00);
      release_rsp();

      // Carry chaining
      accept(3'd1, 8'hFF, 8'h01, 1'b0, 1'b0);
      run_issue();
      check("chain_carry_out", 32'(rsp_flags[0]), 32'h1);
      release_rsp();
      accept(3'd1, 8'h00, 8'h00, 1'b0, 1'b1);
      check("chain_alu_fi", 32'(alu_fi), CHAIN ? 32'h1 : 32'h0);
      run_issue();
      check("chain_d", 32'(rsp_d), CHAIN ? 32'h1 : 32'h0);
      release_rsp();

      // Randomized operations with random backpressure and back-to-back mixes
      for (int i = 0; i < 30; i++) begin
         accept(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
         run_issue();
         backpressure(int'($urandom_range(0, 2)));
         pending = 1'b1;
         if ($urandom_range(0, 1) == 0) begin
            release_rsp();
            pending = 1'b0;
         end
      end
      if (pending) release_rsp();

      // Reset in the middle of ISSUE, after an op that left carry=1 stored
      accept(3'd1, 8'hFF, 8'h01, 1'b0, 1'b0);
      run_issue();
      accept(3'd2, 8'h10, 8'h01, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_reset();
      ref_carry = 1'b0;
      tick();
      tick();
      check_reset();
      rst = 1'b1;
      rsp_ready = 1'b1;
      tick();
      for (int k = 0; k < LAT + 3; k++) begin
         check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
         check("post_rst_req_ready", 32'(req_ready), 32'h1);
         tick();
      end
      accept(3'd1, 8'h00, 8'h00, 1'b0, 1'b1);
      run_issue();
      check("post_rst_chain_d", 32'(rsp_d), 32'h0);
      release_rsp();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
